legv8_multicycle_control: RTL and testbench
===========================================

Name: legv8_multicycle_control

Overview:
- Multicycle LEGv8 main control FSM. It is the producer side of the ALU-control interface: it latches a fetched instruction, classifies the 11-bit opcode, and drives ALUOp/OpcodeField into the existing ALU control unit, plus datapath strobes, across EXEC/MEM/WB cycles.
- It sits between instruction fetch (valid/ready handshake) and the datapath/data memory (mem_ready handshake).

Parameters:
- MEM_TIMEOUT, 16, maximum MEM-state cycles waiting for mem_ready before abort (2..255).
- CNT_W, 8, width of the MEM wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  fetch presents an instruction.
- instr  in  32  instruction word; OpcodeField = instr[31:21].
- instr_ready  out  1  FSM accepts an instruction; high only in IDLE.
- zero  in  1  ALU zero flag, sampled in EXEC.
- mem_ready  in  1  data memory completes the access this cycle.
- ALUOp  out  2  to ALU control: 00 add (LDUR/STUR), 01 pass-B (CBZ), 10 R-type funct, 11 never driven.
- OpcodeField  out  11  latched instr[31:21]; 0 in IDLE.
- ALUSrc, Reg2Loc, MemRead, MemWrite, MemtoReg, RegWrite, PCWrite  out  1 each  datapath strobes.
- illegal  out  1  one-cycle pulse on an unrecognised opcode.
- mem_error  out  1  one-cycle pulse on MEM timeout.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, instruction register=0, counter=0, all outputs 0, including instr_ready. instr_ready rises on the first clk edge after reset_n deasserts.
- Handshake: accept when instr_valid & instr_ready at the rising edge. The instruction register captures instr and the state leaves IDLE the same edge. instr is not sampled elsewhere; changes mid-operation are ignored.
- Opcode classes, priority top-down:
  - R-type, full 11 bits: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - LDUR 11111000010.
  - STUR 11111000000.
  - CBZ, instr[31:24] = 10110100.
  - B, instr[31:26] = 000101.
  - Anything else is illegal.
- States: IDLE, EXEC, MEM, WB, ERR. Outputs are Moore, decoded from the registered state and the latched class.
- IDLE: instr_ready=1. All strobes 0, ALUOp=00. On accept go to EXEC, or to ERR if the class is illegal.
- EXEC (1 cycle):
  - R-type: ALUOp=10, Reg2Loc=0, ALUSrc=0; next WB.
  - LDUR: ALUOp=00, ALUSrc=1; next MEM.
  - STUR: ALUOp=00, ALUSrc=1, Reg2Loc=1; next MEM.
  - CBZ: ALUOp=01, Reg2Loc=1, PCWrite=zero; next IDLE.
  - B: PCWrite=1; next IDLE.
- MEM:
  - MemRead (LDUR) or MemWrite (STUR) is held high every cycle in MEM. The counter clears on MEM entry and increments each MEM cycle.
  - If mem_ready=1: LDUR goes to WB, STUR goes to IDLE. mem_ready wins over timeout in the same cycle.
  - Else if counter == MEM_TIMEOUT-1: pulse mem_error for that cycle and go to IDLE, with no WB.
  - mem_ready outside MEM is ignored.
- WB (1 cycle): RegWrite=1; MemtoReg=1 for LDUR, 0 for R-type; next IDLE.
- ERR (1 cycle): illegal=1, all strobes 0; next IDLE.
- Latency from accept edge to instr_ready high again:
  - R-type 3 cycles.
  - CBZ/B 2 cycles.
  - LDUR 3 + (MEM cycles).
  - STUR 2 + (MEM cycles).
  - Illegal 2 cycles.
- Back-to-back: an instruction may be accepted on the first IDLE cycle.
- Reset mid-operation: immediate return to reset values. A pending memory access is abandoned and no WB occurs.
- Invariants:
  - At most one of MemRead/MemWrite is high.
  - RegWrite and MemWrite are never high together.
  - OpcodeField is stable from EXEC through WB.

Decomposition:
- Package legv8_ctrl_pkg holds:
  - 11-bit opcode constants for ADD/SUB/AND/ORR/LDUR/STUR, the CBZ 8-bit and B 6-bit prefixes.
  - ALUOp encodings (ALUOP_ADD=00, ALUOP_PASSB=01, ALUOP_RTYPE=10).
  - Class enum (CL_RTYPE, CL_LDUR, CL_STUR, CL_CBZ, CL_B, CL_ILL).
  - State enum.
- Sub-module legv8_opcode_classifier: purely combinational, instr[31:21] to class. The top instantiates it on the live instr for the accept decision and registers the class alongside the instruction register.

Test Plan:
- Reset with reset_n=0 asynchronously mid-cycle -> every output 0 immediately. After release, instr_ready=1 on the next edge and ALUOp=00.
- Accept ADD, instr[31:21]=10001011000 -> EXEC shows ALUOp=10, OpcodeField=10001011000, ALUSrc=0. WB shows RegWrite=1, MemtoReg=0. instr_ready returns 3 cycles after accept. Repeat for SUB, AND and ORR with their OpcodeFields.
- LDUR 11111000010 with mem_ready after 3 MEM cycles -> MemRead=1 for exactly 3 cycles, then WB with RegWrite=1 and MemtoReg=1. STUR 11111000000 with mem_ready on the first MEM cycle -> MemWrite=1 for 1 cycle, no RegWrite.
- STUR with mem_ready never asserted, MEM_TIMEOUT=16 -> MemWrite high for 16 cycles, mem_error pulses on the 16th, then IDLE. Repeat with mem_ready=1 on the 16th cycle -> no mem_error.
- CBZ with zero=1 -> EXEC shows ALUOp=01, PCWrite=1. CBZ with zero=0 -> PCWrite=0. B -> PCWrite=1. All three return to IDLE after 2 cycles.
- Opcode 11111111111 -> illegal pulses 1 cycle and no strobes fire. Assert reset_n=0 during the LDUR MEM state -> immediate IDLE with no WB/RegWrite.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multicycle main control: opcodes, ALUOp codes,
// instruction classes and FSM states.
package legv8_ctrl_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  PFX_CBZ = 8'b10110100;
  localparam logic [5:0]  PFX_B   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [2:0] {
    CL_RTYPE,
    CL_LDUR,
    CL_STUR,
    CL_CBZ,
    CL_B,
    CL_ILL
  } class_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_ERR
  } state_t;

endpackage

// File: rtl/legv8_multicycle_control_classifier.sv
// Combinational opcode classifier: maps instr[31:21] to an instruction class,
// full 11-bit matches taking priority over the CBZ/B prefix matches.
module legv8_opcode_classifier
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output class_t      op_class
);

  always_comb begin
    op_class = CL_ILL;
    if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR) begin
      op_class = CL_RTYPE;
    end else if (opcode == OP_LDUR) begin
      op_class = CL_LDUR;
    end else if (opcode == OP_STUR) begin
      op_class = CL_STUR;
    end else if (opcode[10:3] == PFX_CBZ) begin
      op_class = CL_CBZ;
    end else if (opcode[10:5] == PFX_B) begin
      op_class = CL_B;
    end
  end

endmodule

// File: rtl/legv8_multicycle_control.sv
// Multicycle LEGv8 main control FSM: accepts an instruction from fetch, drives
// ALUOp/OpcodeField to ALU control and datapath strobes through EXEC/MEM/WB.
module legv8_multicycle_control
  import legv8_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [1:0]  ALUOp,
  output logic [10:0] OpcodeField,
  output logic        ALUSrc,
  output logic        Reg2Loc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        PCWrite,
  output logic        illegal,
  output logic        mem_error,
  output logic [2:0]  fsm_state
);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_ready is high only in IDLE once out of reset.

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state, state_next;
  class_t           live_class, cls_q;
  logic [10:0]      op_q;
  logic [CNT_W-1:0] cnt;
  logic             started;
  logic             accept;
  logic             unused_instr_bits;

  assign unused_instr_bits = ^instr[20:0];

  legv8_opcode_classifier u_classifier (
    .opcode   (instr[31:21]),
    .op_class (live_class)
  );

  assign accept      = instr_valid & instr_ready;
  assign OpcodeField = (state == ST_IDLE) ? 11'd0 : op_q;
  assign fsm_state   = state;

  // started holds instr_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      op_q    <= 11'd0;
      cls_q   <= CL_ILL;
      cnt     <= '0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      state   <= state_next;
      if (accept) begin
        op_q  <= instr[31:21];
        cls_q <= live_class;
      end
      if (state == ST_MEM) cnt <= cnt + 1'b1;
      else                 cnt <= '0;
    end
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    ALUOp       = ALUOP_ADD;
    ALUSrc      = 1'b0;
    Reg2Loc     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    PCWrite     = 1'b0;
    illegal     = 1'b0;
    mem_error   = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = started;
        if (instr_valid && started) begin
          state_next = (live_class == CL_ILL) ? ST_ERR : ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_next = ST_IDLE;
        case (cls_q)
          CL_RTYPE: begin
            ALUOp      = ALUOP_RTYPE;
            state_next = ST_WB;
          end
          CL_LDUR: begin
            ALUSrc     = 1'b1;
            state_next = ST_MEM;
          end
          CL_STUR: begin
            ALUSrc     = 1'b1;
            Reg2Loc    = 1'b1;
            state_next = ST_MEM;
          end
          CL_CBZ: begin
            ALUOp   = ALUOP_PASSB;
            Reg2Loc = 1'b1;
            PCWrite = zero;
          end
          CL_B:    PCWrite = 1'b1;
          default: state_next = ST_IDLE;
        endcase
      end
      ST_MEM: begin
        MemRead  = (cls_q == CL_LDUR);
        MemWrite = (cls_q == CL_STUR);
        // mem_ready on the final allowed cycle still completes the access.
        if (mem_ready) begin
          state_next = (cls_q == CL_LDUR) ? ST_WB : ST_IDLE;
        end else if (cnt == LAST_CNT) begin
          mem_error  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = (cls_q == CL_LDUR);
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        illegal    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Randomized self-checking bench for legv8_multicycle_control: a per-instruction
// timeline model predicts every output cycle by cycle, plus latency and reset checks.
module tb_legv8_multicycle_control;

  localparam int T = 16;

  localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  ALUOp;
  logic [10:0] OpcodeField;
  logic        ALUSrc, Reg2Loc, MemRead, MemWrite, MemtoReg, RegWrite, PCWrite;
  logic        illegal, mem_error;
  logic [2:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  legv8_multicycle_control #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .ALUOp       (ALUOp),
    .OpcodeField (OpcodeField),
    .ALUSrc      (ALUSrc),
    .Reg2Loc     (Reg2Loc),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .PCWrite     (PCWrite),
    .illegal     (illegal),
    .mem_error   (mem_error),
    .fsm_state   (fsm_state)
  );

  logic [22:0] obs;
  assign obs = {instr_ready, ALUOp, OpcodeField, ALUSrc, Reg2Loc, MemRead, MemWrite,
                MemtoReg, RegWrite, PCWrite, illegal, mem_error};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [22:0] mk(input bit rdy, input logic [1:0] aop, input logic [10:0] opf,
                                     input bit asrc, input bit r2l, input bit mrd, input bit mwr,
                                     input bit m2r, input bit rwr, input bit pcw, input bit ill,
                                     input bit merr);
    return {rdy, aop, opf, asrc, r2l, mrd, mwr, m2r, rwr, pcw, ill, merr};
  endfunction

  function automatic int classify(input logic [10:0] op);
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return C_R;
    if (op == 11'b11111000010) return C_LD;
    if (op == 11'b11111000000) return C_ST;
    if (op[10:3] == 8'b10110100) return C_CBZ;
    if (op[10:5] == 6'b000101) return C_B;
    return C_ILL;
  endfunction

  // driver + scoreboard: one instruction offered in IDLE, then each predicted cycle checked.
  // lat = MEM cycle on which mem_ready rises (0 = never).
  task automatic run_instr(input logic [10:0] op, input bit zero_v, input int lat);
    logic [22:0] exp_q[$];
    bit          mr_q[$];
    bit          z_q[$];
    logic [22:0] e;
    int          cls, mcnt, busy, exp_lat, step;
    bit          done_ok;
    cls = classify(op);
    exp_lat = 0;
    case (cls)
      C_R: begin
        exp_q.push_back(mk(0, 2'b10, op, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 2'b00, op, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        mr_q = '{1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
        z_q  = '{zero_v, 1'($urandom_range(0, 1))};
        exp_lat = 3;
      end
      C_CBZ, C_B, C_ILL: begin
        if (cls == C_CBZ)    exp_q.push_back(mk(0, 2'b01, op, 0, 1, 0, 0, 0, 0, zero_v, 0, 0));
        else if (cls == C_B) exp_q.push_back(mk(0, 2'b00, op, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        else                 exp_q.push_back(mk(0, 2'b00, op, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        mr_q.push_back(1'($urandom_range(0, 1)));
        z_q.push_back(zero_v);
        exp_lat = 2;
      end
      default: begin
        exp_q.push_back(mk(0, 2'b00, op, 1, cls == C_ST, 0, 0, 0, 0, 0, 0, 0));
        mr_q.push_back(1'($urandom_range(0, 1)));
        z_q.push_back(zero_v);
        done_ok = (lat >= 1 && lat <= T);
        mcnt = done_ok ? lat : T;
        for (int i = 1; i <= mcnt; i++) begin
          exp_q.push_back(mk(0, 2'b00, op, 0, 0, cls == C_LD, cls == C_ST, 0, 0, 0, 0,
                             !done_ok && i == T));
          mr_q.push_back(i == lat);
          z_q.push_back(1'($urandom_range(0, 1)));
        end
        if (done_ok && cls == C_LD) begin
          exp_q.push_back(mk(0, 2'b00, op, 0, 0, 0, 0, 1, 1, 0, 0, 0));
          mr_q.push_back(1'($urandom_range(0, 1)));
          z_q.push_back(1'($urandom_range(0, 1)));
        end
        exp_lat = ((cls == C_LD && done_ok) ? 3 : 2) + mcnt;
      end
    endcase

    instr       = {op, 21'($urandom)};
    instr_valid = 1'b1;
    mem_ready   = 1'($urandom_range(0, 1));
    zero        = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_eq("idle", 32'(obs), 32'(mk(1, 2'b00, 11'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = $urandom;
    busy = 0;
    step = 0;
    while (exp_q.size() > 0) begin
      e         = exp_q.pop_front();
      mem_ready = mr_q.pop_front();
      zero      = z_q.pop_front();
      step++;
      @(negedge clk);
      check_eq($sformatf("cls%0d_step%0d", cls, step), 32'(obs), 32'(e));
      if (!instr_ready) busy++;
      @(posedge clk);
      #1;
    end
    check_eq($sformatf("cls%0d_latency", cls), 32'(busy + 1), 32'(exp_lat));
  endtask

  logic [10:0] rops[4];

  initial begin
    rops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    zero        = 1'b0;
    mem_ready   = 1'b0;
    #12;
    check_eq("rst_low", 32'(obs), 32'd0);
    reset_n = 1'b1;
    #1;
    check_eq("rst_release", 32'(obs), 32'd0);
    @(posedge clk);
    #1;

    // directed cases
    foreach (rops[i]) run_instr(rops[i], 1'b0, 0);
    run_instr(11'b11111000010, 1'b0, 3);
    run_instr(11'b11111000000, 1'b0, 1);
    run_instr(11'b11111000000, 1'b0, 0);
    run_instr(11'b11111000000, 1'b1, T);
    run_instr(11'b11111000010, 1'b0, 0);
    run_instr({8'b10110100, 3'($urandom)}, 1'b1, 0);
    run_instr({8'b10110100, 3'($urandom)}, 1'b0, 0);
    run_instr({6'b000101, 5'($urandom)}, 1'b0, 0);
    run_instr(11'b11111111111, 1'b1, 0);

    // reset asserted mid-cycle while an LDUR waits in MEM
    instr       = {11'b11111000010, 21'($urandom)};
    instr_valid = 1'b1;
    mem_ready   = 1'b0;
    @(negedge clk);
    check_eq("rst_mem_idle", 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_mem_rd", 32'(obs), 32'(mk(0, 2'b00, 11'b11111000010, 0, 0, 1, 0, 0, 0, 0, 0, 0)));
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_op", 32'(obs), 32'd0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_held", 32'(obs), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_no_wb", 32'(obs), 32'd0);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;

    // randomized mix
    for (int n = 0; n < 60; n++) begin
      int k;
      logic [10:0] op;
      k = $urandom_range(0, 8);
      case (k)
        0, 1, 2, 3: op = rops[k];
        4: op = 11'b11111000010;
        5: op = 11'b11111000000;
        6: op = {8'b10110100, 3'($urandom)};
        7: op = {6'b000101, 5'($urandom)};
        default: op = 11'($urandom);
      endcase
      run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, T + 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
